// File: rtl/id_scoreboard_if.sv
// rtl/id_scoreboard_if.sv - decoder/issue/EX handshake bundle for id_scoreboard
//
// Signals:
//   in_valid/in_ready    decoder -> scoreboard instruction handshake
//   src1_*/src2_*        source operand enables and entry addresses
//   dst_en/addr/lat      destination entry and cycles until forwardable
//   in_payload           opaque decoded fields
//   out_valid/out_ready  issue register -> EX handshake (out_ready also advances countdowns)
//   out_payload          registered payload
//   flush                kill the issue register
// Modports: slave = scoreboard view, master = decoder/EX view.

interface id_scoreboard_if #(
    parameter int ADDR_W    = 6,
    parameter int LAT_W     = 3,
    parameter int PAYLOAD_W = 128
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 src1_en;
    logic [ADDR_W-1:0]    src1_addr;
    logic                 src2_en;
    logic [ADDR_W-1:0]    src2_addr;
    logic                 dst_en;
    logic [ADDR_W-1:0]    dst_addr;
    logic [LAT_W-1:0]     dst_lat;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 flush;

    modport slave (
        input  in_valid, src1_en, src1_addr, src2_en, src2_addr,
               dst_en, dst_addr, dst_lat, in_payload, out_ready, flush,
        output in_ready, out_valid, out_payload
    );

    modport master (
        output in_valid, src1_en, src1_addr, src2_en, src2_addr,
               dst_en, dst_addr, dst_lat, in_payload, out_ready, flush,
        input  in_ready, out_valid, out_payload
    );
endinterface

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - register-hazard scoreboard and ID/EX issue register
//
// Tracks, per destination entry (GPRs 1..31, HI=32, LO=33), the cycles left
// until its result is forwardable, stalls decoded instructions with RAW or
// WAW hazards, and registers issued instructions into a one-entry output stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   sb           handshake bundle (id_scoreboard_if.slave)
//   stallreq_o   in_valid while blocked by a hazard
//   busy_o       per-entry "countdown nonzero" vector (bit 0 always 0)
//   stall_cnt_o  saturating stall-cycle counter (only with ID_SB_STATS_EN)
//
// Optional feature macro: ID_SB_STATS_EN

module id_scoreboard #(
    parameter int NUM_REGS  = 34,
    parameter int ADDR_W    = 6,
    parameter int LAT_W     = 3,
    parameter int PAYLOAD_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    id_scoreboard_if.slave      sb,
    output logic                stallreq_o,
`ifdef ID_SB_STATS_EN
    output logic [31:0]         stall_cnt_o,
`endif
    output logic [NUM_REGS-1:0] busy_o
);

    // Entry 0 has no storage: it reads as zero and is never loaded.
    logic [LAT_W-1:0]     cnt_q [1:NUM_REGS-1];
    logic [LAT_W-1:0]     cnt_d [1:NUM_REGS-1];
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

    logic [LAT_W-1:0] src1_cnt, src2_cnt, dst_cnt;
    logic             hazard, space, in_ready, issue, dst_track;

    // Address decode by comparison: out-of-range and entry-0 addresses
    // never match a tracked entry, so they read as zero.
    always_comb begin
        src1_cnt = '0;
        src2_cnt = '0;
        dst_cnt  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (sb.src1_addr == ADDR_W'(i)) src1_cnt = cnt_q[i];
            if (sb.src2_addr == ADDR_W'(i)) src2_cnt = cnt_q[i];
            if (sb.dst_addr  == ADDR_W'(i)) dst_cnt  = cnt_q[i];
        end
    end

    assign dst_track = sb.dst_en && (sb.dst_addr != '0) && (sb.dst_lat != '0);

    // WAW: a younger writer may not finish before an older one to the same entry.
    assign hazard = (sb.src1_en && (src1_cnt != '0))
                 || (sb.src2_en && (src2_cnt != '0))
                 || (dst_track && (dst_cnt > sb.dst_lat));

    assign space    = !out_valid_q || sb.out_ready;
    assign in_ready = space && !hazard && !sb.flush;
    assign issue    = sb.in_valid && in_ready;

    assign sb.in_ready    = in_ready;
    assign sb.out_valid   = out_valid_q;
    assign sb.out_payload = out_payload_q;
    assign stallreq_o     = sb.in_valid && hazard;

    // Countdowns: a load this cycle wins over the decrement of the same entry.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue && dst_track && (sb.dst_addr == ADDR_W'(i))) begin
                cnt_d[i] = sb.dst_lat;
            end else if (sb.out_ready && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        if (issue) begin
            out_valid_d   = 1'b1;
            out_payload_d = sb.in_payload;
        end else if (sb.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (sb.flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) cnt_q[i] <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
        end
    end

    always_comb begin
        busy_o    = '0;
        for (int i = 1; i < NUM_REGS; i++) busy_o[i] = (cnt_q[i] != '0);
    end

`ifdef ID_SB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallreq_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - self-checking bench for id_scoreboard

module tb_id_scoreboard;

    logic        clk;
    logic        rst;
    logic        stallreq_o;
    logic [33:0] busy_o;
`ifdef ID_SB_STATS_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] exp_q [$];
    logic [127:0] last_pay;

    id_scoreboard_if #(.ADDR_W(6), .LAT_W(3), .PAYLOAD_W(128)) ifc ();

    id_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .sb         (ifc),
        .stallreq_o (stallreq_o),
`ifdef ID_SB_STATS_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every transfer out of the issue register must match the
    // oldest expected payload.
    always @(negedge clk) begin
        if (rst && ifc.out_valid && ifc.out_ready && !ifc.flush) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got %h, expected nothing", ifc.out_payload);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (ifc.out_payload !== e) begin
                    bad++;
                    $display("FAIL scoreboard_payload: got %h, expected %h", ifc.out_payload, e);
                end
            end
        end
    end

    task automatic idle_inputs();
        ifc.in_valid   = 1'b0;
        ifc.src1_en    = 1'b0;
        ifc.src1_addr  = '0;
        ifc.src2_en    = 1'b0;
        ifc.src2_addr  = '0;
        ifc.dst_en     = 1'b0;
        ifc.dst_addr   = '0;
        ifc.dst_lat    = '0;
        ifc.in_payload = '0;
        ifc.out_ready  = 1'b1;
        ifc.flush      = 1'b0;
    endtask

    // Presents one instruction until accepted. Out_ready is dropped for stall
    // cycles [hs, hs+hl). Returns stall-cycle count and the accepting edge.
    task automatic issue_instr(input logic s1e, input logic [5:0] s1a,
                               input logic de, input logic [5:0] da, input logic [2:0] dl,
                               input int hs, input int hl,
                               output int stalls, output int icyc);
        logic [127:0] p;
        bit done;
        p = {$urandom, $urandom, $urandom, $urandom};
        ifc.src1_en    = s1e;
        ifc.src1_addr  = s1a;
        ifc.src2_en    = 1'b0;
        ifc.src2_addr  = '0;
        ifc.dst_en     = de;
        ifc.dst_addr   = da;
        ifc.dst_lat    = dl;
        ifc.in_payload = p;
        ifc.in_valid   = 1'b1;
        stalls = 0;
        icyc   = -1;
        done   = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            ifc.out_ready = (stalls >= hs && stalls < hs + hl) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (ifc.in_ready) begin
                exp_q.push_back(p);
                last_pay = p;
                @(posedge clk);
                #1;
                icyc = cyc;
                done = 1;
            end else begin
                if (stallreq_o) stalls++;
                @(posedge clk);
                #1;
            end
        end
        idle_inputs();
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue_timeout: got no acceptance in 100 cycles, expected acceptance");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            ifc.in_valid   = 1'($urandom);
            ifc.src1_en    = 1'($urandom);
            ifc.src1_addr  = 6'($urandom_range(0, 33));
            ifc.dst_en     = 1'($urandom);
            ifc.dst_addr   = 6'($urandom_range(0, 33));
            ifc.dst_lat    = 3'($urandom);
            ifc.in_payload = {$urandom, $urandom, $urandom, $urandom};
            ifc.out_ready  = 1'($urandom);
            ifc.flush      = 1'b0;
        end
        @(negedge clk);
        total++;
        if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, expected 0", ifc.out_valid); end
        total++;
        if (busy_o !== 34'd0) begin bad++; $display("FAIL reset_busy: got %h, expected 0", busy_o); end
        total++;
        if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, expected 1", ifc.in_ready); end
        total++;
        if (stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stallreq: got %b, expected 0", stallreq_o); end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        begin
            int s, c;
            issue_instr(1'b0, 6'd0, 1'b1, 6'd3, 3'd0, 0, 0, s, c);
        end
        @(negedge clk);
        total++;
        if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL alu_out_valid: got %b, expected 1", ifc.out_valid); end
        total++;
        if (busy_o !== 34'd0) begin bad++; $display("FAIL alu_busy: got %h, expected 0", busy_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        int s0, c0, s1, c1;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd4, 3'd1, 0, 0, s0, c0);
        issue_instr(1'b1, 6'd4, 1'b1, 6'd9, 3'd0, 0, 0, s1, c1);
        total++;
        if (s1 != 1) begin bad++; $display("FAIL loaduse_stalls: got %0d, expected 1", s1); end
        total++;
        if (c1 - c0 != 2) begin bad++; $display("FAIL loaduse_gap: got %0d, expected 2", c1 - c0); end
`ifdef ID_SB_STATS_EN
        total++;
        if (stall_cnt_o !== 32'd1) begin bad++; $display("FAIL stats_count: got %0d, expected 1", stall_cnt_o); end
`endif
    endtask

    task automatic test_back_to_back();
        int s0, c0, s1, c1;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd8, 3'd0, 0, 0, s0, c0);
        issue_instr(1'b1, 6'd8, 1'b1, 6'd10, 3'd0, 0, 0, s1, c1);
        total++;
        if (s1 != 0 || c1 - c0 != 1) begin
            bad++;
            $display("FAIL b2b: got stalls=%0d gap=%0d, expected stalls=0 gap=1", s1, c1 - c0);
        end
    endtask

    task automatic test_long_mult();
        int s0, c0, s1, c1;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd32, 3'd5, 0, 0, s0, c0);
        issue_instr(1'b1, 6'd32, 1'b1, 6'd11, 3'd0, 0, 0, s1, c1);
        total++;
        if (s1 != 5) begin bad++; $display("FAIL mult_stalls: got %0d, expected 5", s1); end
        total++;
        if (c1 - c0 != 6) begin bad++; $display("FAIL mult_gap: got %0d, expected 6", c1 - c0); end
        issue_instr(1'b0, 6'd0, 1'b1, 6'd32, 3'd5, 0, 0, s0, c0);
        issue_instr(1'b1, 6'd32, 1'b1, 6'd11, 3'd0, 1, 3, s1, c1);
        total++;
        if (s1 != 8) begin bad++; $display("FAIL mult_hold_stalls: got %0d, expected 8", s1); end
        total++;
        if (c1 - c0 != 9) begin bad++; $display("FAIL mult_hold_gap: got %0d, expected 9", c1 - c0); end
    endtask

    task automatic test_waw();
        int s0, c0, s1, c1;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd5, 3'd4, 0, 0, s0, c0);
        issue_instr(1'b0, 6'd0, 1'b1, 6'd5, 3'd1, 0, 0, s1, c1);
        total++;
        if (s1 != 3) begin bad++; $display("FAIL waw_stalls: got %0d, expected 3", s1); end
        @(negedge clk);
        total++;
        if (busy_o[5] !== 1'b1) begin bad++; $display("FAIL waw_reload: got busy=%b, expected 1", busy_o[5]); end
        @(negedge clk);
        total++;
        if (busy_o[5] !== 1'b0) begin bad++; $display("FAIL waw_expire: got busy=%b, expected 0", busy_o[5]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reg0();
        int s0, c0, s1, c1;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd0, 3'd7, 0, 0, s0, c0);
        total++;
        if (busy_o !== 34'd0) begin bad++; $display("FAIL reg0_busy: got %h, expected 0", busy_o); end
        issue_instr(1'b1, 6'd0, 1'b0, 6'd0, 3'd0, 0, 0, s1, c1);
        total++;
        if (s1 != 0 || c1 - c0 != 1) begin
            bad++;
            $display("FAIL reg0_stall: got stalls=%0d gap=%0d, expected stalls=0 gap=1", s1, c1 - c0);
        end
    endtask

    task automatic test_flush();
        int s0, c0;
        logic [127:0] held;
        issue_instr(1'b0, 6'd0, 1'b0, 6'd0, 3'd0, 0, 0, s0, c0);
        held = last_pay;
        void'(exp_q.pop_back());
        ifc.flush      = 1'b1;
        ifc.in_valid   = 1'b1;
        ifc.in_payload = ~held;
        @(negedge clk);
        total++;
        if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b, expected 0", ifc.in_ready); end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b, expected 0", ifc.out_valid); end
        total++;
        if (ifc.out_payload !== held) begin bad++; $display("FAIL flush_payload: got %h, expected %h", ifc.out_payload, held); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int s0, c0;
        issue_instr(1'b0, 6'd0, 1'b1, 6'd7, 3'd5, 0, 0, s0, c0);
        #3;
        rst = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (ifc.out_valid !== 1'b0 || busy_o !== 34'd0) begin
            bad++;
            $display("FAIL async_reset: got out_valid=%b busy=%h, expected 0/0", ifc.out_valid, busy_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b, expected 1", ifc.in_ready); end
    endtask

    initial begin
        idle_inputs();
        last_pay = '0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_long_mult();
        test_waw();
        test_reg0();
        test_flush();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL drain: got %0d pending, expected 0", exp_q.size()); end
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-hazard scoreboard and ID/EX issue register for the MIPS pipeline. It sits between the decoder and the execute stage. For every architectural destination (GPRs plus HI/LO) it tracks how many cycles remain until the result becomes forwardable, and holds back a decoded instruction while any of its sources, or its destination (WAW), is still in flight. Issued instructions are registered into a one-entry valid/ready output stage.

## Interface
Parameters:
- NUM_REGS, 34: tracked entries. Indices 0–31 are GPRs, 32 is HI, 33 is LO. Entry 0 is never tracked.
- ADDR_W, 6: source/destination address width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- LAT_W, 3: latency/countdown width. Maximum latency is 2^LAT_W−1.
- PAYLOAD_W, 128: width of the opaque decoded-instruction payload carried to EX.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset (0 = reset).
- in_valid, in, 1: decoder presents an instruction.
- in_ready, out, 1: instruction accepted this cycle.
- src1_en / src2_en, in, 1 each: source operand is read.
- src1_addr / src2_addr, in, ADDR_W each: source entries.
- dst_en, in, 1: instruction writes a destination.
- dst_addr, in, ADDR_W: destination entry.
- dst_lat, in, LAT_W: cycles after issue before the result is forwardable. 0 means the result is forwardable immediately and is not tracked.
- in_payload, in, PAYLOAD_W: decoded fields.
- out_valid, out, 1: issue register is full.
- out_ready, in, 1: EX accepts the issue register; also the pipeline-advance qualifier for the countdowns.
- out_payload, out, PAYLOAD_W: registered payload.
- flush, in, 1: kill the issue register.
- stallreq_o, out, 1: in_valid asserted but the instruction is blocked by a hazard.
- busy_o, out, NUM_REGS: per-entry "count ≠ 0" vector.

## Operation
- State:
  - cnt[i] (LAT_W bits) for i = 1..NUM_REGS−1; cnt[0] is hard-wired to 0.
  - Output register: out_valid and out_payload.
- Hazard is asserted when any of the following holds:
  - src1_en, src1_addr ≠ 0, and cnt[src1_addr] ≠ 0;
  - src2_en, src2_addr ≠ 0, and cnt[src2_addr] ≠ 0;
  - dst_en, dst_addr ≠ 0, dst_lat ≠ 0, and cnt[dst_addr] > dst_lat (WAW ordering).
- space = !out_valid | out_ready.
- in_ready = space & !hazard. This is combinational and independent of in_valid.
- issue = in_valid & in_ready.
- stallreq_o = in_valid & hazard.
- On issue:
  - out_payload ← in_payload; out_valid ← 1.
  - If dst_en, dst_addr ≠ 0 and dst_lat ≠ 0: cnt[dst_addr] ← dst_lat.
- When out_valid & out_ready & !issue: out_valid ← 0.
- Countdown: in every cycle with out_ready = 1, each nonzero cnt[i] decrements by 1, except an entry loaded this cycle.
  - On a simultaneous load and decrement of the same entry, the load wins and the value is not decremented.
  - Counters saturate at 0 and never wrap.
  - With out_ready = 0, all counts hold.
- flush:
  - out_valid ← 0 next edge, overriding any issue in the same cycle.
  - in_ready is forced to 0 while flush = 1.
  - Counters are not cleared. This is conservative: at worst it costs stall cycles, never correctness.
- Out-of-range addresses (≥ NUM_REGS) read as count 0 and are never loaded.

## Timing
- Reset values: all cnt = 0, out_valid = 0, out_payload = 0, busy_o = 0. Combinationally, in_ready = 1 and stallreq_o = 0.
- Issue latency: 1 cycle from accepted in_valid to out_valid.
- Producer issued at edge t with latency L:
  - cnt = L after edge t, then L−1 after edge t+1, and so on.
  - A dependent consumer is first accepted at edge t+L+1, provided out_ready stays high.
- L = 1 (load-use) therefore inserts exactly one bubble. L = 0 allows back-to-back issue.
- Reset asserted mid-operation: all state clears asynchronously; the in-flight instruction is lost.
- Pure combinational paths: hazard → in_ready and hazard → stallreq_o. No in_valid → in_ready path.

## Configuration
- ID_SB_STATS_EN defined:
  - Adds output stall_cnt_o, 32 bits, reset value 0.
  - Increments every cycle stallreq_o = 1 and saturates at 0xFFFF_FFFF.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- **Reset:** hold rst = 0 with random inputs → out_valid = 0, busy_o = 0, in_ready = 1. After release, issue one ALU op (dst $3, lat 0) → out_valid = 1 one cycle later, busy_o = 0.
- **Load-use:** issue a load (dst $4, lat 1), then an add reading $4, out_ready = 1 → stallreq_o = 1 for exactly 1 cycle and the add issues 2 cycles after the load.
- **Long multiply:** issue MULT (dst HI = 32, lat 5), then MFHI reading entry 32 → 5 stall cycles. Hold out_ready = 0 for 3 of those cycles → 8 stall cycles, cnt[32] frozen during the hold.
- **WAW:** issue dst $5 lat 4, then an instruction with dst $5 lat 1 → blocked until cnt[5] ≤ 1, i.e. 3 stall cycles. Then cnt[5] reloads to 1.
- **Register $0:** issue dst $0 lat 7, then a read of $0 → no stall and busy_o[0] = 0 throughout.
- **Flush vs issue:** flush and in_valid together → in_ready = 0, out_valid = 0 next cycle, payload not captured. With ID_SB_STATS_EN, stall_cnt_o after the load-use case equals 1.
